fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 126 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one requester the FIFO write port for a
// whole packet (or up to MAX_BEATS beats), then re-arbitrates after one idle cycle.
module fifo_wr_arbiter #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MAX_BEATS  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          fifo_wen,
    output logic [DATA_WIDTH-1:0]         fifo_write_data,
    input  logic                          fifo_full,
    input  logic                          fifo_almost_full,
    output logic                          busy
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = $clog2(MAX_BEATS) + 1;

    typedef enum logic [0:0] {
        StIdle,
        StLocked
    } state_e;

    state_e              state_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic                busy_q;
    logic [CntW-1:0]     beat_cnt_q;
    logic [IdxW-1:0]     owner_q;
    logic [IdxW-1:0]     last_owner_q;

    logic                win_found;
    logic [IdxW-1:0]     win_idx;
    logic [NUM_REQ-1:0]  win_onehot;
    logic [IdxW-1:0]     cand;

    logic                xfer;
    logic                owner_last;
    logic                beat_limit;

    // Search starts just after the previous owner so it gets the lowest priority.
    always_comb begin
        win_found  = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        cand       = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            cand = IdxW'((int'(last_owner_q) + k) % int'(NUM_REQ));
            if (!win_found && req_valid[cand]) begin
                win_found        = 1'b1;
                win_idx          = cand;
                win_onehot       = '0;
                win_onehot[cand] = 1'b1;
            end
        end
    end

    // Handshake and data path are combinational from the registered grant;
    // reset forces them quiet in the cycle it is asserted.
    always_comb begin
        req_ready       = '0;
        fifo_write_data = '0;
        if (!reset && state_q == StLocked) begin
            req_ready = grant_q & {NUM_REQ{~fifo_full}};
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (grant_q[i]) begin
                    fifo_write_data = fifo_write_data | req_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign xfer       = |(req_valid & req_ready);
    assign owner_last = |(req_last & grant_q);
    assign beat_limit = (beat_cnt_q == CntW'(MAX_BEATS - 1));

    assign fifo_wen = xfer;
    assign grant    = grant_q;
    assign busy     = busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            busy_q       <= 1'b0;
            beat_cnt_q   <= '0;
            owner_q      <= '0;
            last_owner_q <= IdxW'(NUM_REQ - 1);
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (win_found && !fifo_almost_full) begin
                        state_q    <= StLocked;
                        grant_q    <= win_onehot;
                        owner_q    <= win_idx;
                        busy_q     <= 1'b1;
                        beat_cnt_q <= '0;
                    end
                end
                StLocked: begin
                    if (xfer) begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        // Packet end or beat budget exhausted both hand the port back.
                        if (owner_last || beat_limit) begin
                            state_q      <= StIdle;
                            grant_q      <= '0;
                            busy_q       <= 1'b0;
                            last_owner_q <= owner_q;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a per-cycle behavioural model and
// hand-computed grant/data sequences.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int W     = 4;
    localparam int MB    = 16;
    localparam int DEPTH = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid, req_last, req_ready, grant;
    logic [N*W-1:0] req_data;
    logic           fifo_wen, fifo_full, fifo_almost_full, busy;
    logic [W-1:0]   fifo_write_data;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .DATA_WIDTH(W),
        .NUM_REQ   (N),
        .MAX_BEATS (MB)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_last        (req_last),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .grant           (grant),
        .fifo_wen        (fifo_wen),
        .fifo_write_data (fifo_write_data),
        .fifo_full       (fifo_full),
        .fifo_almost_full(fifo_almost_full),
        .busy            (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Packet sources: one beat array per requester, popped on handshake.
    logic [W-1:0] bdata [N][DEPTH];
    logic         blast [N][DEPTH];
    int           head  [N];
    int           tail  [N];
    logic         src_en[N];
    logic         hs    [N];

    task automatic push_beat(int r, int d, logic l);
        bdata[r][tail[r]] = W'(d);
        blast[r][tail[r]] = l;
        tail[r]++;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            logic v;
            v = src_en[i] && (head[i] < tail[i]);
            req_valid[i]       = v;
            req_last[i]        = v ? blast[i][head[i]] : 1'b0;
            req_data[i*W +: W] = v ? bdata[i][head[i]] : '0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (hs[i]) head[i]++;
        drive();
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (head[i] < tail[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Model state and logs
    int           m_owner = -1;
    int           m_cnt   = 0;
    int           m_last  = N - 1;
    bit           m_init  = 1'b0;
    int           cyc     = 0;
    logic [N-1:0] prev_grant = '0;
    logic [W-1:0] wlog[$];
    int           glog[$];
    int           gcyc[$];
    int           stall_cnt = 0;
    int           hold_cnt  = 0;

    initial begin
        forever begin
            logic [N-1:0] e_ready, e_grant;
            logic         e_wen, e_busy;
            logic [W-1:0] e_data;
            @(negedge clk);
            cyc++;
            for (int i = 0; i < N; i++) hs[i] = req_valid[i] & req_ready[i];
            if (m_init) begin
                e_ready = '0; e_wen = 1'b0; e_data = '0; e_grant = '0;
                e_busy  = (m_owner >= 0);
                if (m_owner >= 0) e_grant[m_owner] = 1'b1;
                if (!reset && m_owner >= 0) begin
                    e_ready[m_owner] = !fifo_full;
                    e_wen  = req_valid[m_owner] && !fifo_full;
                    e_data = req_data[m_owner*W +: W];
                end
                check("grant", grant, e_grant);
                check("busy", busy, e_busy);
                check("req_ready", req_ready, e_ready);
                check("fifo_wen", fifo_wen, e_wen);
                check("fifo_write_data", fifo_write_data, e_data);
            end
            if (fifo_wen === 1'b1) wlog.push_back(fifo_write_data);
            if (prev_grant == '0 && grant != '0) begin
                for (int i = 0; i < N; i++) if (grant[i]) glog.push_back(i);
                gcyc.push_back(cyc);
            end
            prev_grant = grant;
            if (grant != '0 && fifo_full && !fifo_wen) stall_cnt++;
            if (grant != '0 && !fifo_full && !fifo_wen) hold_cnt++;
            // Advance model to the state after the coming rising edge
            if (reset) begin
                m_owner = -1; m_cnt = 0; m_last = N - 1; m_init = 1'b1;
            end else if (m_owner < 0) begin
                if (req_valid != '0 && !fifo_almost_full) begin
                    for (int k = 1; k <= N; k++) begin
                        int c;
                        c = (m_last + k) % N;
                        if (m_owner < 0 && req_valid[c]) m_owner = c;
                    end
                    m_cnt = 0;
                end
            end else if (req_valid[m_owner] && !fifo_full) begin
                m_cnt++;
                if (req_last[m_owner] || m_cnt == MB) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end
    end

    task automatic reset_dut();
        reset = 1'b1; fifo_full = 1'b0; fifo_almost_full = 1'b0;
        drive();
        step();
        step();
        for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; src_en[i] = 1'b1; end
        reset = 1'b0;
        drive();
    endtask

    task automatic wait_log(string name, int n, int limit);
        for (int k = 0; k < limit && wlog.size() < n; k++) step();
        check({"wait_", name}, wlog.size(), n);
    endtask

    task automatic wait_drain(string name, int limit);
        for (int k = 0; k < limit && !all_empty(); k++) step();
        check({"drain_", name}, 32'(all_empty()), 1);
        step();
        step();
    endtask

    function automatic void check_w(string name, int base, int k, int exp);
        check($sformatf("%s[%0d]", name, k),
              (base + k < wlog.size()) ? 32'(wlog[base + k]) : 32'hdead, exp);
    endfunction

    function automatic void check_g(string name, int base, int k, int exp);
        check($sformatf("%s[%0d]", name, k),
              (base + k < glog.size()) ? 32'(glog[base + k]) : 32'hdead, exp);
    endfunction

    int wb, gb, sb, hb;

    initial begin
        for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; src_en[i] = 1'b1; hs[i] = 1'b0; end
        reset = 1'b1; fifo_full = 1'b0; fifo_almost_full = 1'b0;
        drive();
        step();
        check("reset_grant", grant, 0);
        check("reset_busy", busy, 0);
        check("reset_ready", req_ready, 0);
        check("reset_wen", fifo_wen, 0);

        // All four requesters, 2-beat packets; requester 0 has a second packet
        reset_dut();
        wb = wlog.size(); gb = glog.size();
        for (int r = 0; r < N; r++) begin
            push_beat(r, 2*r + 1, 1'b0);
            push_beat(r, 2*r + 2, 1'b1);
        end
        push_beat(0, 9, 1'b0);
        push_beat(0, 10, 1'b1);
        drive();
        wait_drain("rr", 200);
        for (int k = 0; k < 5; k++) check_g("rr_order", gb, k, (k == 4) ? 0 : k);
        for (int k = 0; k < 10; k++) check_w("rr_data", wb, k, k + 1);
        check("rr_count", wlog.size() - wb, 10);
        for (int k = 1; k < 5; k++)
            check($sformatf("rr_gap[%0d]", k),
                  (gb + k < gcyc.size()) ? 32'(gcyc[gb+k] - gcyc[gb+k-1]) : 32'hdead, 3);

        // FIFO full for 3 cycles during beat 2
        reset_dut();
        wb = wlog.size(); sb = stall_cnt;
        push_beat(2, 5, 1'b0); push_beat(2, 6, 1'b0); push_beat(2, 7, 1'b1);
        drive();
        wait_log("full", wb + 1, 20);
        fifo_full = 1'b1; drive();
        step(); step(); step();
        fifo_full = 1'b0; drive();
        wait_drain("full", 50);
        check("full_stall_cycles", stall_cnt - sb, 3);
        check("full_count", wlog.size() - wb, 3);
        for (int k = 0; k < 3; k++) check_w("full_data", wb, k, 5 + k);

        // Forced release after MAX_BEATS
        reset_dut();
        wb = wlog.size(); gb = glog.size();
        for (int k = 0; k < 20; k++) push_beat(1, k % 16, 1'b0);
        push_beat(3, 10, 1'b1);
        drive();
        wait_drain("maxb", 200);
        for (int k = 0; k < 21; k++)
            check_w("maxb_data", wb, k, (k < 16) ? k : (k == 16) ? 10 : k - 17);
        check_g("maxb_order", gb, 0, 1);
        check_g("maxb_order", gb, 1, 3);
        check_g("maxb_order", gb, 2, 1);

        // almost_full blocks arbitration in IDLE but not an existing grant
        reset_dut();
        wb = wlog.size(); gb = glog.size();
        fifo_almost_full = 1'b1;
        push_beat(0, 3, 1'b1); push_beat(2, 5, 1'b1);
        drive();
        repeat (4) step();
        check("afull_blocked", grant, 0);
        fifo_almost_full = 1'b0; drive();
        check("afull_still_idle", grant, 0);
        step();
        check("afull_granted", grant, 4'b0001);
        fifo_almost_full = 1'b1; drive();
        repeat (4) step();
        check("afull_locked_done", wlog.size() - wb, 1);
        check("afull_idle_again", grant, 0);
        fifo_almost_full = 1'b0; drive();
        wait_drain("afull", 50);
        check_g("afull_order", gb, 0, 0);
        check_g("afull_order", gb, 1, 2);
        check_w("afull_data", wb, 0, 3);
        check_w("afull_data", wb, 1, 5);

        // Reset during beat 2 of a 4-beat packet
        reset_dut();
        wb = wlog.size();
        for (int k = 1; k <= 4; k++) push_beat(0, k, k == 4);
        push_beat(1, 9, 1'b1);
        drive();
        wait_log("rst", wb + 1, 20);
        reset = 1'b1; drive();
        step();
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_no_write", wlog.size() - wb, 1);
        reset = 1'b0; drive();
        step();
        check("rst_first_winner", grant, 4'b0001);
        wait_drain("rst", 50);
        for (int k = 0; k < 5; k++) check_w("rst_data", wb, k, (k < 4) ? k + 1 : 9);

        // Owner drops valid for 2 cycles while requester 1 waits
        reset_dut();
        wb = wlog.size(); gb = glog.size(); hb = hold_cnt;
        push_beat(0, 1, 1'b0); push_beat(0, 2, 1'b0); push_beat(0, 3, 1'b1);
        push_beat(1, 4, 1'b1);
        drive();
        wait_log("drop", wb + 1, 20);
        src_en[0] = 1'b0; drive();
        step(); step();
        check("drop_grant_held", grant, 4'b0001);
        src_en[0] = 1'b1; drive();
        wait_drain("drop", 50);
        check("drop_hold_cycles", hold_cnt - hb, 2);
        check_g("drop_order", gb, 0, 0);
        check_g("drop_order", gb, 1, 1);
        for (int k = 0; k < 4; k++) check_w("drop_data", wb, k, k + 1);

        // Single requester re-granted after each one-cycle gap
        reset_dut();
        gb = glog.size();
        for (int k = 1; k <= 3; k++) push_beat(2, k, 1'b1);
        drive();
        wait_drain("single", 50);
        for (int k = 0; k < 3; k++) check_g("single_order", gb, k, 2);
        for (int k = 1; k < 3; k++)
            check($sformatf("single_gap[%0d]", k),
                  (gb + k < gcyc.size()) ? 32'(gcyc[gb+k] - gcyc[gb+k-1]) : 32'hdead, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
